// File: rtl/jtag_dr_sync.sv
// System-clock-side JTAG data-register engine: oversamples the raw TAP signals,
// runs an 11-bit DR and exchanges commands/responses with the debug unit.
module jtag_dr_sync #(
  parameter int g_sync_stages = 2
) (
  input  logic       clk_sys_i,
  input  logic       rst_n_i,
  input  logic       tck_i,
  input  logic       tdi_i,
  input  logic       capture_i,
  input  logic       shift_i,
  input  logic       update_i,
  input  logic       tap_reset_i,
  output logic       tdo_o,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic [2:0] cmd_addr_o,
  output logic [7:0] cmd_data_o,
  input  logic [7:0] rsp_data_i,
  input  logic       rsp_valid_i,
  output logic       rsp_ack_o,
  output logic       overrun_o
);

  // Bit order of the synchronizer bundle; all six travel through the same chain.
  localparam int TCK = 0;
  localparam int TDI = 1;
  localparam int CAP = 2;
  localparam int SHF = 3;
  localparam int UPD = 4;
  localparam int RST = 5;

  logic [5:0]  w_tap_raw;
  logic [5:0]  r_sync [g_sync_stages];
  logic [5:0]  w_tap_s;
  logic        r_tck_d;
  logic        w_tck_rise;
  logic        w_xfer;

  logic [10:0] r_sr;
  logic        r_tdo;
  logic        r_cmd_valid;
  logic [2:0]  r_cmd_addr;
  logic [7:0]  r_cmd_data;
  logic        r_rsp_ack;
  logic        r_overrun;

  logic [10:0] w_sr_next;
  logic        w_cmd_valid_next;
  logic [2:0]  w_cmd_addr_next;
  logic [7:0]  w_cmd_data_next;
  logic        w_rsp_ack_next;
  logic        w_overrun_next;

  assign w_tap_raw = {tap_reset_i, update_i, shift_i, capture_i, tdi_i, tck_i};
  assign w_tap_s   = r_sync[g_sync_stages-1];

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < g_sync_stages; i++) begin
        r_sync[i] <= '0;
      end
      r_tck_d <= 1'b0;
    end else begin
      r_sync[0] <= w_tap_raw;
      for (int i = 1; i < g_sync_stages; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_tck_d <= w_tap_s[TCK];
    end
  end

  assign w_tck_rise = w_tap_s[TCK] & ~r_tck_d;
  assign w_xfer     = r_cmd_valid & cmd_ready_i;

  always_comb begin
    w_sr_next        = r_sr;
    w_cmd_valid_next = r_cmd_valid;
    w_cmd_addr_next  = r_cmd_addr;
    w_cmd_data_next  = r_cmd_data;
    w_rsp_ack_next   = 1'b0;
    w_overrun_next   = r_overrun;

    if (w_xfer) begin
      w_cmd_valid_next = 1'b0;
    end

    if (w_tck_rise) begin
      if (w_tap_s[RST]) begin
        // TAP reset leaves a pending command alone so it can still drain.
        w_sr_next      = '0;
        w_overrun_next = 1'b0;
      end else if (w_tap_s[CAP]) begin
        w_sr_next      = {r_overrun, r_cmd_valid, rsp_valid_i, rsp_data_i};
        w_rsp_ack_next = rsp_valid_i;
        w_overrun_next = 1'b0;
      end else if (w_tap_s[SHF]) begin
        w_sr_next = {w_tap_s[TDI], r_sr[10:1]};
      end else if (w_tap_s[UPD]) begin
        // The slot is free if empty or if it drains on this very edge.
        if (!r_cmd_valid || w_xfer) begin
          w_cmd_addr_next  = r_sr[10:8];
          w_cmd_data_next  = r_sr[7:0];
          w_cmd_valid_next = 1'b1;
        end else begin
          w_overrun_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sr        <= '0;
      r_tdo       <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_rsp_ack   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sr        <= w_sr_next;
      r_tdo       <= r_sr[0];
      r_cmd_valid <= w_cmd_valid_next;
      r_cmd_addr  <= w_cmd_addr_next;
      r_cmd_data  <= w_cmd_data_next;
      r_rsp_ack   <= w_rsp_ack_next;
      r_overrun   <= w_overrun_next;
    end
  end

  assign tdo_o       = r_tdo;
  assign cmd_valid_o = r_cmd_valid;
  assign cmd_addr_o  = r_cmd_addr;
  assign cmd_data_o  = r_cmd_data;
  assign rsp_ack_o   = r_rsp_ack;
  assign overrun_o   = r_overrun;

endmodule
